// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between the memory stage and a word-only data memory
// (256x32, async read, sync write). It sizes and aligns byte/half/word accesses,
// sign/zero-extends loads and does sub-word stores as read-modify-write.
//
// Optional feature macro: LSU_MISALIGN_EN
//   defined   - accesses crossing a word boundary are split into two memory cycles
//   undefined - such accesses fault at accept; the second-word state is not built
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   req_valid/req_ready    request handshake (accepted when both high)
//   req_we, req_funct3     store/load select, RISC-V size code
//   req_addr, req_wdata    byte address, LSB-aligned store data
//   resp_valid             one-cycle response pulse
//   resp_rdata, resp_err   extended load data (held), fault flag
//   mem_we, mem_addr       data memory write enable, word-aligned address
//   mem_wdata, mem_rdata   data memory write/read data
module dmem_lsu #(
  parameter int unsigned ADDR_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  // Number of bytes touched for a funct3 size field.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    logic [2:0] n;
    case (sz)
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Replace the bytes of one memory word that fall inside [off, off+n).
  // Lanes of the second word are numbered 4..7, so both words share one rule.
  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] wd,
                                             input logic [1:0]  off,
                                             input logic [2:0]  n,
                                             input logic        second);
    logic [31:0] res;
    logic [2:0]  lane;
    logic [2:0]  stop;
    logic [1:0]  src;
    res  = old_w;
    stop = {1'b0, off} + n;
    for (int j = 0; j < 4; j++) begin
      lane = {second, 2'(j)};
      src  = 2'(j) - off;
      if (lane >= {1'b0, off} && lane < stop)
        res[8*j +: 8] = wd[{src, 3'b000} +: 8];
    end
    return res;
  endfunction

  // Gather bytes off.. from lo (spilling into hi) and extend per funct3.
  function automatic logic [31:0] load_value(input logic [31:0] lo,
                                             input logic [31:0] hi,
                                             input logic [1:0]  off,
                                             input logic [2:0]  f3);
    logic [31:0] raw;
    logic [31:0] res;
    logic [2:0]  lane;
    for (int i = 0; i < 4; i++) begin
      lane = 3'(i) + {1'b0, off};
      raw[8*i +: 8] = lane[2] ? hi[{lane[1:0], 3'b000} +: 8]
                              : lo[{lane[1:0], 3'b000} +: 8];
    end
    case (f3)
      3'b000:  res = {{24{raw[7]}}, raw[7:0]};
      3'b001:  res = {{16{raw[15]}}, raw[15:0]};
      3'b100:  res = {24'd0, raw[7:0]};
      3'b101:  res = {16'd0, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic        rdata_en;
  logic [31:0] rdata_d;

  logic        accept_c;
  logic [2:0]  req_nbytes_c;
  logic [32:0] req_last_c;
  logic        req_illegal_c;
  logic        req_oob_c;
  logic        req_fault_c;
  logic [2:0]  nbytes_q;
  logic [31:0] word_addr;

  assign accept_c     = req_valid && (state_q == IDLE);
  assign req_nbytes_c = size_bytes(req_funct3[1:0]);
  // 33-bit sum so an access wrapping past 0xFFFFFFFF lands above the limit.
  assign req_last_c   = {1'b0, req_addr} + 33'(req_nbytes_c) - 33'd1;
  assign req_oob_c    = req_last_c >= 33'(ADDR_LIMIT);
  assign req_illegal_c = (req_funct3[1:0] == 2'b11) ||
                         (req_we ? req_funct3[2] : (req_funct3 == 3'b110));

`ifdef LSU_MISALIGN_EN
  logic        cross_q;
  logic [31:0] word0_q;
  assign req_fault_c = req_illegal_c || req_oob_c;
  assign cross_q     = ({1'b0, addr_q[1:0]} + nbytes_q) > 3'd4;
`else
  logic        req_cross_c;
  assign req_cross_c = ({1'b0, req_addr[1:0]} + req_nbytes_c) > 3'd4;
  assign req_fault_c = req_illegal_c || req_oob_c || req_cross_c;
`endif

  assign nbytes_q  = size_bytes(funct3_q[1:0]);
  assign word_addr = {addr_q[31:2], 2'b00};

  // State and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept_c) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        err_q    <= req_fault_c;
      end
      if (rdata_en) rdata_q <= rdata_d;
    end
  end

`ifdef LSU_MISALIGN_EN
  // First word of a split load, held for assembly in the second cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               word0_q <= 32'd0;
    else if (state_q == ACC0) word0_q <= mem_rdata;
  end
`endif

  // Next state and response data.
  always_comb begin
    state_d  = state_q;
    rdata_en = 1'b0;
    rdata_d  = 32'd0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d  = req_fault_c ? RESP : ACC0;
          rdata_en = req_fault_c;
        end
      end
      ACC0: begin
        state_d  = RESP;
        rdata_en = 1'b1;
        rdata_d  = we_q ? 32'd0 : load_value(mem_rdata, mem_rdata, addr_q[1:0], funct3_q);
`ifdef LSU_MISALIGN_EN
        if (cross_q) begin
          state_d  = ACC1;
          rdata_en = 1'b0;
        end
`endif
      end
`ifdef LSU_MISALIGN_EN
      ACC1: begin
        state_d  = RESP;
        rdata_en = 1'b1;
        rdata_d  = we_q ? 32'd0 : load_value(word0_q, mem_rdata, addr_q[1:0], funct3_q);
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory-side signals decode straight from state so reset drops mem_we at once.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (state_q == ACC0 || state_q == ACC1) begin
      mem_we   = we_q;
      mem_addr = (state_q == ACC1) ? word_addr + 32'd4 : word_addr;
      if (we_q)
        mem_wdata = merge_word(mem_rdata, wdata_q, addr_q[1:0], nbytes_q, state_q == ACC1);
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = (state_q == RESP) && err_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Testbench for dmem_lsu: word memory model, scoreboard of expected responses,
// latency / write-count / memory-content checks, and a mid-access reset.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  dmem_lsu #(.ADDR_LIMIT(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory model with a preload port used only while the unit is idle.
  logic [31:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = 8'd0;
  logic [31:0] pl_data = 32'd0;
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_we)     mem[mem_addr[9:2]] <= mem_wdata;
    else if (pl_en) mem[pl_idx] <= pl_data;
  end

  int we_cycles = 0;
  always @(posedge clk) if (mem_we) we_cycles <= we_cycles + 1;

  typedef struct packed { logic [31:0] rdata; logic err; } exp_t;
  exp_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: every response pulse pops one expectation.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
  end

  task automatic preload(input logic [7:0] idx, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Issue one request, scramble req_* after accept, measure latency and writes.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int exp_we);
    int cyc;
    int we0;
    bit seen;
    @(negedge clk);
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    exp_q.push_back(exp_t'{rdata: exp_rd, err: exp_err});
    we0 = we_cycles;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111;
    req_addr = 32'hFFFF_FFF0; req_wdata = 32'hFFFF_FFFF;
    cyc = 1; seen = 1'b0;
    while (!seen && cyc <= 8) begin
      if (resp_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        #1 cyc++;
      end
    end
    check({tag, ".lat"}, 32'(cyc), 32'(exp_lat));
    if (!seen) exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    #1;
    check({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
    check({tag, ".we_cycles"}, 32'(we_cycles - we0), 32'(exp_we));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    #12;
    check("rst.ready", 32'(req_ready), 32'd1);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.resp_rdata", resp_rdata, 32'd0);
    check("rst.resp_err", 32'(resp_err), 32'd0);
    check("rst.mem_we", 32'(mem_we), 32'd0);
    check("rst.mem_addr", mem_addr, 32'd0);
    check("rst.mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    preload(8'd4, 32'hDEAD_BEEF);
    preload(8'd5, 32'h0123_4567);
    preload(8'd255, 32'h0BAD_F00D);

    // Aligned loads.
    do_req("lw_10",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0);
    do_req("lb_13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0, 2, 0);
    do_req("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_00DE, 1'b0, 2, 0);
    do_req("lh_12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_DEAD, 1'b0, 2, 0);
    do_req("lhu_10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000_BEEF, 1'b0, 2, 0);
    do_req("lb_10",  1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFF_FFEF, 1'b0, 2, 0);
    do_req("lbu_15", 1'b0, 3'b100, 32'h15, 32'h0, 32'h0000_0045, 1'b0, 2, 0);

    // Word-crossing load.
`ifdef LSU_MISALIGN_EN
    do_req("lw_12", 1'b0, 3'b010, 32'h12, 32'h0, 32'h4567_DEAD, 1'b0, 3, 0);
    do_req("lh_13", 1'b0, 3'b001, 32'h13, 32'h0, 32'h0000_67DE, 1'b0, 3, 0);
`else
    do_req("lw_12", 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, 1, 0);
    do_req("lh_13", 1'b0, 3'b001, 32'h13, 32'h0, 32'h0, 1'b1, 1, 0);
`endif

    // Faults: illegal codes, address limit, wrap.
    do_req("ld_f011",  1'b0, 3'b011, 32'h10,  32'h0, 32'h0, 1'b1, 1, 0);
    do_req("st_f100",  1'b1, 3'b100, 32'h10,  32'h0, 32'h0, 1'b1, 1, 0);
    do_req("lw_3fc",   1'b0, 3'b010, 32'h3FC, 32'h0, 32'h0BAD_F00D, 1'b0, 2, 0);
    do_req("lw_400",   1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1, 1, 0);
    do_req("lh_3ff",   1'b0, 3'b001, 32'h3FF, 32'h0, 32'h0, 1'b1, 1, 0);
    do_req("lw_wrap",  1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1, 1, 0);
    check("fault.mem4", mem[4], 32'hDEAD_BEEF);

    // Sub-word and word stores.
    preload(8'd4, 32'h1122_3344);
    do_req("sb_11", 1'b1, 3'b000, 32'h11, 32'h0000_AB55, 32'h0, 1'b0, 2, 1);
    check("sb_11.mem", mem[4], 32'h1122_5544);
    do_req("sh_12", 1'b1, 3'b001, 32'h12, 32'hFFFF_9876, 32'h0, 1'b0, 2, 1);
    check("sh_12.mem", mem[4], 32'h9876_5544);
    do_req("sw_18", 1'b1, 3'b010, 32'h18, 32'hA5A5_0F0F, 32'h0, 1'b0, 2, 1);
    check("sw_18.mem", mem[6], 32'hA5A5_0F0F);

`ifdef LSU_MISALIGN_EN
    do_req("sh_13", 1'b1, 3'b001, 32'h13, 32'h0000_BEEF, 32'h0, 1'b0, 3, 2);
    check("sh_13.mem4", mem[4], 32'hEF76_5544);
    check("sh_13.mem5", mem[5], 32'h0123_45BE);

    // Reset during the second cycle of a split store.
    preload(8'd3, 32'h1122_3344);
    preload(8'd4, 32'h5566_7788);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h0E; req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("rst_mid.acc0_we", 32'(mem_we), 32'd1);
    @(posedge clk);
    #1;
    check("rst_mid.acc1_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid.we_drop", 32'(mem_we), 32'd0);
    check("rst_mid.no_resp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid.ready", 32'(req_ready), 32'd1);
    check("rst_mid.mem0c", mem[3], 32'hF00D_3344);
    check("rst_mid.mem10", mem[4], 32'h5566_7788);
`else
    do_req("sh_13", 1'b1, 3'b001, 32'h13, 32'h0000_BEEF, 32'h0, 1'b1, 1, 0);
    check("sh_13.mem4", mem[4], 32'h9876_5544);
    check("sh_13.mem5", mem[5], 32'h0123_4567);
`endif

    repeat (2) @(negedge clk);
    check("end.queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit between the core's memory stage and the word-only data memory (`D_MEM`, 256×32, async read, sync write on `MemRW`).
- Sizes and aligns byte, half and word accesses and sign/zero-extends loads.
- Implements sub-word stores as read-modify-write.
- With `LSU_MISALIGN_EN`, splits accesses that cross a word boundary into two memory cycles.
- Requests use a valid/ready handshake; results return as a one-cycle response pulse.

## Interface
Parameters:
- `ADDR_LIMIT`, 1024: byte size of data memory. Any accessed byte at or above it is a fault.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit idle; a request is accepted on an edge with `req_valid && req_ready`
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RISC-V size code:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
  - stores: 000 SB, 001 SH, 010 SW
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, LSB-aligned
- `resp_valid`  out  1  one-cycle response pulse
- `resp_rdata`  out  32  extended load data; 0 for stores and faults
- `resp_err`  out  1  fault flag, valid with `resp_valid`
- `mem_we`  out  1  to D_MEM `MemRW`
- `mem_addr`  out  32  to D_MEM `addr`, always word-aligned
- `mem_wdata`  out  32  to D_MEM `write_data`
- `mem_rdata`  in  32  from D_MEM `read_data`

## Operation
States: IDLE, ACC0, ACC1, RESP.

- **IDLE**
  - `req_ready`=1; all other outputs 0 except held `resp_rdata`.
  - On accept, register we/funct3/addr/wdata and evaluate faults.
  - Any fault: go to RESP with err=1.
  - No fault: go to ACC0.
- **Faults**, all decided at accept so memory is never touched:
  - illegal funct3: 011, 110, 111 for loads; any funct3[2]=1 for stores;
  - any byte of the access at or above `ADDR_LIMIT`, computed in 33 bits so wrap past 0xFFFFFFFF is a fault;
  - misaligned access (half at offset 3, word at offsets 1–3) when `LSU_MISALIGN_EN` is undefined.
- **ACC0**
  - `mem_addr` = {addr[31:2],2'b00}.
  - Loads: capture `mem_rdata`.
  - Stores: `mem_wdata` = `mem_rdata` with the target bytes replaced by `req_wdata` bytes (little-endian); `mem_we`=1.
  - Next state: ACC1 if the access crosses into the next word, else RESP.
- **ACC1** (misaligned only)
  - `mem_addr` = word address + 4.
  - Same capture/merge for the remaining bytes: the first word supplies bytes k..3, the second supplies the low bytes.
  - Next state: RESP.
- **RESP**
  - `resp_valid`=1, `resp_err` as decided.
  - `resp_rdata` = assembled load value, sign-extended for LB/LH, zero-extended for LBU/LHU.
  - Next state: IDLE.
- `resp_rdata` holds its value until the next RESP.
- `mem_we` is decoded combinationally from the state register and registered `we`, so it is never active in IDLE or RESP.

## Timing
- **Reset values:** state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- **Latency:** accept at edge E0.
  - Aligned: RESP cycle follows E1, so `resp_valid` is seen at E2.
  - Split: `resp_valid` at E3.
  - Fault: `resp_valid` at E1.
- **Throughput:** `req_ready` is low from accept until back in IDLE, so one request per 3 cycles aligned, 4 split, 2 fault. `req_ready` returns high in the cycle after RESP.
- **Handshake:** `req_*` is sampled only on the accepting edge; changes to `req_*` afterwards are ignored.
- **Stores:** exactly one `mem_we` cycle per touched word.
- **Reset mid-operation:**
  - Return to IDLE immediately; `mem_we` deasserts asynchronously.
  - A first-word write already committed in a split store is not undone; no response is issued.

## Configuration
- `LSU_MISALIGN_EN` defined: boundary-crossing accesses use ACC1 and complete normally.
- Undefined: such accesses return `resp_err`=1 with no memory cycle, and the ACC1 state logic is omitted.

## Test plan
- LW 0x10 with mem[0x10]=0xDEADBEEF → `resp_valid` 2 cycles after accept, rdata 0xDEADBEEF, err 0, `mem_we` never high.
- Same word:
  - LB 0x13 → 0xFFFFFFDE
  - LBU 0x13 → 0x000000DE
  - LH 0x12 → 0xFFFFDEAD
  - LHU 0x10 → 0x0000BEEF
- SB 0x11, wdata 0xAB55, with mem[0x10]=0x11223344 → single `mem_we` pulse, word becomes 0x11225544, rdata 0.
- LW 0x12 with mem[0x10]=0xDEADBEEF, mem[0x14]=0x01234567:
  - macro defined → rdata 0x4567DEAD at 3 cycles;
  - undefined → err=1 at 1 cycle, no `mem_we`.
- Faults, each giving err=1, rdata 0, no memory access:
  - funct3 011 load;
  - SB with funct3 100;
  - LW 0x3FC with `ADDR_LIMIT`=1024 succeeds, LW 0x400 faults;
  - LH 0x3FF faults.
- SW 0x0E, 0xCAFEF00D, macro on:
  - rst_n pulsed low during ACC1 → `mem_we` drops immediately, no `resp_valid`, mem[0x0C] upper half = 0xF00D, mem[0x10] unchanged, `req_ready`=1 after release.
